// File: rtl/reg_read_responder.sv
// Shared register bank with one write port and CORES round-robin read requesters.
// Reads complete one cycle after the handshake; a same-edge write is forwarded to the reader.
module reg_read_responder #(
  parameter int WIDTH  = 12,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int CORES  = 4
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [CORES-1:0]         req_valid,
  input  logic [CORES*ADDR_W-1:0]  req_addr,
  output logic [CORES-1:0]         req_ready,
  output logic [CORES-1:0]         rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy
);

  localparam int PTR_W = (CORES > 1) ? $clog2(CORES) : 1;

  logic [WIDTH-1:0]  bank_q [DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CORES-1:0]  pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0]  pend_data_q, pend_data_d;

  logic [CORES-1:0]  grant;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_any;
  logic              handshake;
  int unsigned       scan_int;
  logic [PTR_W-1:0]  scan_sel;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else if (wr_en && (int'(wr_addr) < DEPTH)) begin
      bank_q[wr_addr] <= wr_data;
    end
  end

  // Rotating priority: the first valid requester at or after ptr_q wins.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    scan_int  = 0;
    scan_sel  = '0;
    for (int i = 0; i < CORES; i++) begin
      scan_int = (int'(ptr_q) + i) % CORES;
      scan_sel = PTR_W'(scan_int);
      if (!grant_any && req_valid[scan_sel]) begin
        grant_any = 1'b1;
        grant_idx = scan_sel;
      end
    end
  end

  // Grants are suppressed while reset is held so no handshake can be seen.
  always_comb begin
    handshake = grant_any && rst;
    grant     = '0;
    if (handshake) grant[grant_idx] = 1'b1;
  end

  assign rd_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];

  always_comb begin
    if (int'(rd_addr) >= DEPTH) begin
      rd_data = '0;
    end else if (wr_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end else begin
      rd_data = bank_q[rd_addr];
    end
  end

  always_comb begin
    pend_valid_d = grant;
    pend_data_d  = pend_data_q;
    ptr_d        = ptr_q;
    if (handshake) begin
      pend_data_d = rd_data;
      ptr_d       = PTR_W'((int'(grant_idx) + 1) % CORES);
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      ptr_q        <= '0;
      pend_valid_q <= '0;
      pend_data_q  <= '0;
    end else begin
      ptr_q        <= ptr_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = pend_valid_q;
  assign rsp_data  = pend_data_q;
  assign busy      = |req_valid;

endmodule

// File: tb/tb_reg_read_responder.sv
// Self-checking bench for reg_read_responder: directed vector table, reset corner
// sequences and a randomized run against a simple array/pointer reference model.
module tb_reg_read_responder;
  localparam int W = 12;
  localparam int D = 12;
  localparam int A = 4;
  localparam int C = 4;

  logic           clock = 1'b0;
  logic           rst;
  logic           wr_en;
  logic [A-1:0]   wr_addr;
  logic [W-1:0]   wr_data;
  logic [C-1:0]   req_valid;
  logic [C*A-1:0] req_addr;
  logic [C-1:0]   req_ready;
  logic [C-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  reg_read_responder #(.WIDTH(W), .DEPTH(D), .ADDR_W(A), .CORES(C)) dut (
    .clock(clock), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [11:0]  wr_data;
    logic [3:0]   req_valid;
    logic [15:0]  req_addr;
    logic [3:0]   exp_ready;
    logic [3:0]   exp_rsp_valid;
    logic [11:0]  exp_rsp_data;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  logic [11:0] m_bank [D];
  int          m_ptr;
  logic [11:0] m_data;
  logic [3:0]  m_exp_ready;
  int          gk;
  int          k;
  logic [3:0]  a;

  initial begin
    // Directed vectors; each row applies inputs for one cycle, checks the grant,
    // then checks the response produced by that row's handshake.
    vecs[0]  = '{1'b1, 4'd3,  12'h456, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 12'h000};
    vecs[1]  = '{1'b0, 4'd0,  12'h000, 4'b0010, 16'h0030, 4'b0010, 4'b0010, 12'h456};
    vecs[2]  = '{1'b1, 4'd0,  12'h100, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 12'h456};
    vecs[3]  = '{1'b1, 4'd1,  12'h101, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 12'h456};
    vecs[4]  = '{1'b1, 4'd2,  12'h102, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 12'h456};
    vecs[5]  = '{1'b1, 4'd3,  12'h103, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 12'h456};
    vecs[6]  = '{1'b0, 4'd0,  12'h000, 4'b1000, 16'h3000, 4'b1000, 4'b1000, 12'h103};
    vecs[7]  = '{1'b0, 4'd0,  12'h000, 4'b1111, 16'h3210, 4'b0001, 4'b0001, 12'h100};
    vecs[8]  = '{1'b0, 4'd0,  12'h000, 4'b1111, 16'h3210, 4'b0010, 4'b0010, 12'h101};
    vecs[9]  = '{1'b0, 4'd0,  12'h000, 4'b1111, 16'h3210, 4'b0100, 4'b0100, 12'h102};
    vecs[10] = '{1'b0, 4'd0,  12'h000, 4'b1111, 16'h3210, 4'b1000, 4'b1000, 12'h103};
    vecs[11] = '{1'b0, 4'd0,  12'h000, 4'b1111, 16'h3210, 4'b0001, 4'b0001, 12'h100};
    vecs[12] = '{1'b1, 4'd5,  12'h123, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 12'h100};
    vecs[13] = '{1'b1, 4'd5,  12'h789, 4'b0100, 16'h0500, 4'b0100, 4'b0100, 12'h789};
    vecs[14] = '{1'b1, 4'd14, 12'hABC, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 12'h789};
    vecs[15] = '{1'b0, 4'd0,  12'h000, 4'b0001, 16'h000E, 4'b0001, 4'b0001, 12'h000};
    vecs[16] = '{1'b0, 4'd0,  12'h000, 4'b0010, 16'h0000, 4'b0010, 4'b0010, 12'h100};
    vecs[17] = '{1'b0, 4'd0,  12'h000, 4'b0100, 16'h0300, 4'b0100, 4'b0100, 12'h103};
    vecs[18] = '{1'b1, 4'd14, 12'h555, 4'b1000, 16'hE000, 4'b1000, 4'b1000, 12'h000};
    vecs[19] = '{1'b0, 4'd4,  12'hFFF, 4'b0001, 16'h0004, 4'b0001, 4'b0001, 12'h000};

    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_valid = 4'b1111; req_addr = '0;

    // Reset held with all requests pending.
    repeat (2) @(posedge clock);
    #1;
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_data", 32'(rsp_data), 32'h0);
    chk("reset_busy", 32'(busy), 32'h1);
    $display("reset hold: ready=%b rsp_valid=%b rsp_data=%h", req_ready, rsp_valid, rsp_data);

    rst = 1'b1;
    req_valid = 4'b0001; req_addr = 16'h0007;
    #1;
    chk("post_reset_ready", 32'(req_ready), 32'h1);
    edge_step();
    chk("post_reset_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("post_reset_rsp_data", 32'(rsp_data), 32'h0);
    $display("post-reset read: rsp_valid=%b rsp_data=%h", rsp_valid, rsp_data);

    for (int i = 0; i < 20; i++) begin
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      req_valid = vecs[i].req_valid; req_addr = vecs[i].req_addr;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(|vecs[i].req_valid));
      edge_step();
      chk($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_rsp_valid));
      chk($sformatf("vec%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].exp_rsp_data));
      $display("vec %0d: ready=%b rsp_valid=%b rsp_data=%h", i, req_ready, rsp_valid, rsp_data);
    end

    // Reset arrives between grant and edge: the response must never appear.
    wr_en = 1'b0;
    req_valid = 4'b1000; req_addr = 16'h0000;
    #1;
    chk("midrst_grant", 32'(req_ready), 32'h8);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_ready_forced", 32'(req_ready), 32'h0);
    chk("midrst_rsp_cleared", 32'(rsp_valid), 32'h0);
    chk("midrst_data_cleared", 32'(rsp_data), 32'h0);
    edge_step();
    chk("midrst_no_pulse_in_rst", 32'(rsp_valid), 32'h0);
    rst = 1'b1;
    req_valid = 4'b0000;
    edge_step();
    chk("midrst_no_pulse_after", 32'(rsp_valid), 32'h0);
    req_valid = 4'b1001; req_addr = 16'h3003;
    #1;
    chk("midrst_ptr_zero", 32'(req_ready), 32'h1);
    edge_step();
    chk("midrst_bank_cleared_valid", 32'(rsp_valid), 32'h1);
    chk("midrst_bank_cleared_data", 32'(rsp_data), 32'h0);
    #1;
    chk("midrst_next_grant", 32'(req_ready), 32'h8);
    edge_step();
    $display("reset mid-op: rsp_valid=%b rsp_data=%h", rsp_valid, rsp_data);

    // Fresh reset, then randomized traffic against the reference model.
    req_valid = '0; wr_en = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    edge_step();
    for (int i = 0; i < D; i++) m_bank[i] = '0;
    m_ptr = 0;
    m_data = '0;

    for (int n = 0; n < 300; n++) begin
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = 4'($urandom_range(0, 15));
      wr_data   = 12'($urandom);
      req_valid = 4'($urandom);
      req_addr  = 16'($urandom);
      gk = -1;
      for (int i = 0; i < C; i++) begin
        k = (m_ptr + i) % C;
        if (gk < 0 && req_valid[k]) gk = k;
      end
      m_exp_ready = (gk >= 0) ? 4'(1 << gk) : 4'b0000;
      #1;
      chk($sformatf("rnd%0d_ready", n), 32'(req_ready), 32'(m_exp_ready));
      chk($sformatf("rnd%0d_busy", n), 32'(busy), 32'(req_valid != 4'b0000));
      if (wr_en && int'(wr_addr) < D) m_bank[wr_addr] = wr_data;
      if (gk >= 0) begin
        a = req_addr[gk*A +: A];
        m_data = (int'(a) < D) ? m_bank[a] : 12'h000;
        m_ptr = (gk + 1) % C;
      end
      edge_step();
      chk($sformatf("rnd%0d_rsp_valid", n), 32'(rsp_valid), 32'(m_exp_ready));
      chk($sformatf("rnd%0d_rsp_data", n), 32'(rsp_data), 32'(m_data));
      $display("rnd %0d: req_valid=%b ready=%b rsp_valid=%b rsp_data=%h", n, req_valid, m_exp_ready, rsp_valid, rsp_data);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
